id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the ALU.
- Captures decoded instructions from ID and drives the ALU's A, B and 4-bit op inputs during EX.
- Handles operand forwarding from EX/MEM and MEM/WB, load-use stall detection, and flush bubbles.
- Also carries the destination and memory-control bits forward to the EX/MEM register.

Parameters:
- DW, 32, datapath width; must equal the ALU operand width.
- RW, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ready  out  1  stage accepts the ID instruction this cycle (0 = stall ID/IF)
- id_rs_addr  in  RW  source register 1 address
- id_rt_addr  in  RW  source register 2 address
- id_rs_data  in  DW  register file read, port 1
- id_rt_data  in  DW  register file read, port 2
- id_imm  in  DW  sign-extended immediate
- id_use_imm  in  1  B comes from id_imm instead of rt
- id_alu_op  in  4  ALU opcode (0000 add, 0001 sub, 0010 sll1, 0011 srl1, 0100 sra1, 0101 neg, 0110 compare, 0111 and, 1000 or)
- id_dest  in  RW  writeback register
- id_reg_write  in  1  instruction writes a register
- id_mem_read  in  1  load
- id_mem_write  in  1  store
- flush  in  1  discard the ID instruction (branch taken)
- exmem_dest  in  RW  EX/MEM destination
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_result  in  DW  EX/MEM ALU result
- memwb_dest  in  RW  MEM/WB destination
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_result  in  DW  MEM/WB writeback value
- ex_valid  out  1  EX holds a real instruction
- ex_a  out  DW  ALU operand A
- ex_b  out  DW  ALU operand B
- ex_op  out  4  ALU opcode
- ex_store_data  out  DW  rt value for stores
- ex_dest  out  RW  registered id_dest
- ex_reg_write  out  1  registered id_reg_write, gated by valid
- ex_mem_read  out  1  registered id_mem_read, gated by valid
- ex_mem_write  out  1  registered id_mem_write, gated by valid

Behaviour:
- Reset (rst=1 at a clk edge):
  - All EX registers clear; ex_valid=0 and all ex_* outputs are 0 (ex_op=0000).
  - id_ready=0 while rst is high.
- Latency: an instruction accepted at edge N appears on ex_* during cycle N+1.
- Capture bypass (register-file write-through), always on:
  - If memwb_reg_write, memwb_dest!=0 and memwb_dest==id_rs_addr, latch memwb_result instead of id_rs_data.
  - The same rule applies to rt.
- Load-use hazard:
  - hz = ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs_addr | (ex_dest==id_rt_addr & !id_use_imm)) & id_valid.
  - Store rt is also a source: for id_mem_write, an rt match counts even when id_use_imm=1.
- Stall (hz=1 and flush=0):
  - id_ready=0.
  - Next edge loads a bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, data registers hold.
- Flush:
  - flush=1 loads a bubble regardless of hz.
  - id_ready=1 (the wrong-path instruction is consumed).
  - Flush wins over a simultaneous stall.
- Normal (no hz, no flush): id_ready=1; on id_valid=1 capture all fields, ex_valid=1.
- id_valid=0 without stall or flush: load a bubble.
- Register 0 is never a forwarding or hazard match.
- Operand output, combinational from registered values:
  - fa = forwarded rs.
  - ft = forwarded rt.
  - ex_a = fa.
  - ex_b = registered imm if use_imm, else ft.
  - ex_store_data = ft.
  - ex_op = registered op.
  - Shift, neg and compare pass B unchanged; the ALU ignores it where unused.
- Control outputs: all ex_* control bits are 0 whenever ex_valid=0.

Optional Feature:
- Macro: IDEX_FORWARD_EN.
- Defined:
  - fa/ft select exmem_result when exmem_reg_write & exmem_dest!=0 & exmem_dest==registered source.
  - Otherwise they select memwb_result on the equivalent MEM/WB match.
  - Otherwise they select the registered value.
  - EX/MEM has priority over MEM/WB.
  - Only load-use stalls occur.
- Undefined:
  - No EX-time forwarding; fa/ft are the registered values.
  - hz additionally asserts when an ID source matches (ex_valid & ex_reg_write & ex_dest), or (exmem_reg_write & exmem_dest), with nonzero dest.
  - Capture bypass is retained, so every RAW stalls until the writer reaches MEM/WB.

Test Plan:
- Reset: rst high for 2 cycles with id_valid=1 -> ex_valid=0, ex_a=ex_b=0, ex_op=0000, id_ready=0; the first instruction after release appears one cycle later.
- Forward: add $3=$1+$2, then sub $4=$3-$1 with exmem_result=0x00000010 (FORWARD_EN) -> ex_a=0x00000010, ex_op=0001, no stall. Without FORWARD_EN -> id_ready=0 for 2 cycles, then ex_a comes from capture bypass.
- Load-use: lw $5 in EX (ex_mem_read=1), ID reads rs=$5 -> id_ready=0 for one cycle, bubble (ex_valid=0, ex_reg_write=0), then the instruction issues with ex_a=memwb_result.
- Register zero: exmem_dest=0, exmem_reg_write=1, exmem_result=0xDEADBEEF, ID rs=$0 with id_rs_data=0 -> ex_a=0, no stall.
- Flush during stall: hz=1 and flush=1 -> id_ready=1, next cycle ex_valid=0 and all control bits 0.
- Immediate and store: sw with rt=$7, id_use_imm=1, imm=0xFFFFFFFC, memwb writes $7=0x55 at capture -> ex_b=0xFFFFFFFC, ex_store_data=0x00000055, ex_mem_write=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register, operand select, capture bypass and hazard detection.
// Define IDEX_FORWARD_EN for EX-time forwarding; otherwise RAW hazards stall.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_alu_op,
  input  logic [RW-1:0] id_dest,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic [RW-1:0] exmem_dest,
  input  logic          exmem_reg_write,
  input  logic [DW-1:0] exmem_result,
  input  logic [RW-1:0] memwb_dest,
  input  logic          memwb_reg_write,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_op,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs_addr;
    logic [RW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [3:0]    op;
    logic [RW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
  } ex_t;

  ex_t ex_q, ex_d;

  logic          rt_used;
  logic          lu_hz;
  logic          raw_hz;
  logic          hz;
  logic [DW-1:0] fa;
  logic [DW-1:0] ft;

  // Register zero never counts as a producer
  function automatic logic hit(
    input logic          we,
    input logic [RW-1:0] d,
    input logic [RW-1:0] a
  );
    return we & (d != '0) & (d == a);
  endfunction

  // Hazard detection against the ID sources
  always_comb begin
    rt_used = ~id_use_imm | id_mem_write;
    lu_hz = ex_q.valid & ex_q.mem_read &
            (hit(1'b1, ex_q.dest, id_rs_addr) |
             (rt_used & hit(1'b1, ex_q.dest, id_rt_addr)));
`ifdef IDEX_FORWARD_EN
    raw_hz = 1'b0;
`else
    raw_hz = hit(ex_q.reg_write, ex_q.dest, id_rs_addr) |
             (rt_used & hit(ex_q.reg_write, ex_q.dest, id_rt_addr)) |
             hit(exmem_reg_write, exmem_dest, id_rs_addr) |
             (rt_used & hit(exmem_reg_write, exmem_dest, id_rt_addr));
`endif
    hz = id_valid & (lu_hz | raw_hz);
    id_ready = ~rst & (flush | ~hz);
  end

  // Next EX contents: bubble on flush/stall/idle, else capture with write-through
  always_comb begin
    ex_d = ex_q;
    if (flush | hz | ~id_valid) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else begin
      ex_d.valid     = 1'b1;
      ex_d.rs_addr   = id_rs_addr;
      ex_d.rt_addr   = id_rt_addr;
      ex_d.rs_data   = hit(memwb_reg_write, memwb_dest, id_rs_addr) ?
                       memwb_result : id_rs_data;
      ex_d.rt_data   = hit(memwb_reg_write, memwb_dest, id_rt_addr) ?
                       memwb_result : id_rt_data;
      ex_d.imm       = id_imm;
      ex_d.use_imm   = id_use_imm;
      ex_d.op        = id_alu_op;
      ex_d.dest      = id_dest;
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.mem_write = id_mem_write;
    end
  end

  // EX register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // Operand select, EX/MEM before MEM/WB when forwarding
  always_comb begin
    fa = ex_q.rs_data;
    ft = ex_q.rt_data;
`ifdef IDEX_FORWARD_EN
    if (hit(exmem_reg_write, exmem_dest, ex_q.rs_addr))
      fa = exmem_result;
    else if (hit(memwb_reg_write, memwb_dest, ex_q.rs_addr))
      fa = memwb_result;
    if (hit(exmem_reg_write, exmem_dest, ex_q.rt_addr))
      ft = exmem_result;
    else if (hit(memwb_reg_write, memwb_dest, ex_q.rt_addr))
      ft = memwb_result;
`endif
  end

`ifndef IDEX_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{exmem_result, ex_q.rs_addr, ex_q.rt_addr};
`endif

  assign ex_valid      = ex_q.valid;
  assign ex_a          = fa;
  assign ex_b          = ex_q.use_imm ? ex_q.imm : ft;
  assign ex_store_data = ft;
  assign ex_op         = ex_q.op;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign ex_mem_write  = ex_q.valid & ex_q.mem_write;

endmodule
